// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use bubble insertion; define WB_BYPASS_EN to forward writeback data into captured operands
module id_ex_stage (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        Stall,
  input  logic        Flush,
  input  logic        InValid,
  input  logic [4:0]  Rs,
  input  logic [4:0]  Rt,
  input  logic [4:0]  Rd,
  input  logic [4:0]  Shamt,
  input  logic [15:0] Imm,
  input  logic [5:0]  Funct,
  input  logic        RegWrite,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        MemToReg,
  input  logic        ALUSrc,
  input  logic        RegDst,
  input  logic [2:0]  ALUOp,
  input  logic [31:0] ReadData1,
  input  logic [31:0] ReadData2,
  input  logic        WbEn,
  input  logic [4:0]  WbReg,
  input  logic [31:0] WbData,
  output logic        ExValid,
  output logic [4:0]  ExRs,
  output logic [4:0]  ExRt,
  output logic [4:0]  ExRd,
  output logic [4:0]  ExShamt,
  output logic [5:0]  ExFunct,
  output logic [31:0] ExImm,
  output logic [31:0] ExData1,
  output logic [31:0] ExData2,
  output logic        ExRegWrite,
  output logic        ExMemRead,
  output logic        ExMemWrite,
  output logic        ExMemToReg,
  output logic        ExALUSrc,
  output logic        ExRegDst,
  output logic [2:0]  ExALUOp,
  output logic        LoadUseStall
);
  typedef enum logic {EMPTY, FULL} state_t;
  typedef struct packed {
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [31:0] imm, data1, data2;
  } fields_t;
  state_t     state_q, state_d;
  logic [8:0] ctrl_q, ctrl_d, ctrl_in;
  fields_t    fld_q, fld_d, fld_in;
  logic [31:0] data1_in, data2_in;
  logic       load_use;
`ifdef WB_BYPASS_EN
  assign data1_in = (WbEn && WbReg != 5'd0 && WbReg == Rs) ? WbData : ReadData1;
  assign data2_in = (WbEn && WbReg != 5'd0 && WbReg == Rt) ? WbData : ReadData2;
`else
  logic wb_unused;
  assign wb_unused = ^{WbEn, WbReg, WbData};
  assign data1_in  = ReadData1;
  assign data2_in  = ReadData2;
`endif
  assign ctrl_in  = {RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp};
  assign fld_in   = '{Rs, Rt, Rd, Shamt, Funct, {{16{Imm[15]}}, Imm}, data1_in, data2_in};
  // Register 0 is hardwired, so a load targeting it can never create a hazard
  assign load_use = state_q == FULL && ctrl_q[7] && InValid && fld_q.rt != 5'd0 &&
                    (fld_q.rt == Rs || fld_q.rt == Rt);
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      state_q <= EMPTY;
      ctrl_q  <= '0;
      fld_q   <= '0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      fld_q   <= fld_d;
    end
  always_comb
    state_d = Flush ? EMPTY : Stall ? state_q : load_use ? EMPTY : InValid ? FULL : EMPTY;
  always_comb begin
    ctrl_d = Flush ? '0 : Stall ? ctrl_q : (load_use || !InValid) ? '0 : ctrl_in;
    fld_d  = Flush ? '0 : (Stall || load_use) ? fld_q : fld_in;
  end
  assign ExValid      = state_q == FULL;
  assign {ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExRegDst, ExALUOp} = ctrl_q;
  assign ExRs         = fld_q.rs;
  assign ExRt         = fld_q.rt;
  assign ExRd         = fld_q.rd;
  assign ExShamt      = fld_q.shamt;
  assign ExFunct      = fld_q.funct;
  assign ExImm        = fld_q.imm;
  assign ExData1      = fld_q.data1;
  assign ExData2      = fld_q.data2;
  assign LoadUseStall = load_use;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: randomized and directed checks of id_ex_stage against a rule-level model
module tb_id_ex_stage;
  logic clk = 0, rst_n = 0;
  logic stall, flush, in_valid, wb_en;
  logic [4:0] rs, rt, rd, shamt, wb_reg;
  logic [15:0] imm;
  logic [5:0] funct;
  logic [8:0] c;
  logic [31:0] rd1, rd2, wb_data;
  logic ex_valid, ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rdst, lus;
  logic [4:0] ex_rs, ex_rt, ex_rd, ex_sh;
  logic [5:0] ex_fn;
  logic [2:0] ex_op;
  logic [31:0] ex_imm, ex_d1, ex_d2;
  int checks = 0, failures = 0;

  typedef struct packed {
    logic valid;
    logic [8:0] ctrl;
    logic [4:0] rs, rt, rd, sh;
    logic [5:0] fn;
    logic [31:0] imm, d1, d2;
  } ex_t;
  ex_t m;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .Clk(clk), .Reset_n(rst_n), .Stall(stall), .Flush(flush), .InValid(in_valid),
    .Rs(rs), .Rt(rt), .Rd(rd), .Shamt(shamt), .Imm(imm), .Funct(funct),
    .RegWrite(c[8]), .MemRead(c[7]), .MemWrite(c[6]), .MemToReg(c[5]), .ALUSrc(c[4]),
    .RegDst(c[3]), .ALUOp(c[2:0]), .ReadData1(rd1), .ReadData2(rd2),
    .WbEn(wb_en), .WbReg(wb_reg), .WbData(wb_data),
    .ExValid(ex_valid), .ExRs(ex_rs), .ExRt(ex_rt), .ExRd(ex_rd), .ExShamt(ex_sh),
    .ExFunct(ex_fn), .ExImm(ex_imm), .ExData1(ex_d1), .ExData2(ex_d2),
    .ExRegWrite(ex_rw), .ExMemRead(ex_mr), .ExMemWrite(ex_mw), .ExMemToReg(ex_m2r),
    .ExALUSrc(ex_as), .ExRegDst(ex_rdst), .ExALUOp(ex_op), .LoadUseStall(lus)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic hazard(ex_t e);
    return e.valid && e.ctrl[7] && in_valid && e.rt != 0 && (e.rt == rs || e.rt == rt);
  endfunction

  function automatic logic [31:0] fwd(logic [4:0] r, logic [31:0] rf);
`ifdef WB_BYPASS_EN
    if (wb_en && wb_reg != 0 && wb_reg == r) return wb_data;
`endif
    return rf;
  endfunction

  function automatic ex_t next_ex(ex_t e);
    ex_t n = e;
    if (flush) n = '0;
    else if (stall) n = e;
    else if (hazard(e)) begin
      n.valid = 0;
      n.ctrl = 0;
    end else begin
      n.valid = in_valid;
      n.ctrl = in_valid ? c : 9'd0;
      n.rs = rs; n.rt = rt; n.rd = rd; n.sh = shamt; n.fn = funct;
      n.imm = 32'($signed(imm));
      n.d1 = fwd(rs, rd1);
      n.d2 = fwd(rt, rd2);
    end
    return n;
  endfunction

  task automatic check_all();
    chk("valid", 32'(ex_valid), 32'(m.valid));
    chk("ctrl", 32'({ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rdst, ex_op}), 32'(m.ctrl));
    chk("rs", 32'(ex_rs), 32'(m.rs));
    chk("rt", 32'(ex_rt), 32'(m.rt));
    chk("rd", 32'(ex_rd), 32'(m.rd));
    chk("shamt", 32'(ex_sh), 32'(m.sh));
    chk("funct", 32'(ex_fn), 32'(m.fn));
    chk("imm", ex_imm, m.imm);
    chk("data1", ex_d1, m.d1);
    chk("data2", ex_d2, m.d2);
    chk("lus_now", 32'(lus), 32'(rst_n && hazard(m)));
  endtask

  task automatic tick();
    #1;
    chk("lus", 32'(lus), 32'(rst_n && hazard(m)));
    @(posedge clk);
    m = rst_n ? next_ex(m) : '0;
    #1;
    check_all();
  endtask

  task automatic idle();
    stall = 0; flush = 0; in_valid = 0; wb_en = 0;
    rs = 0; rt = 0; rd = 0; shamt = 0; imm = 0; funct = 0; c = 0;
    rd1 = 0; rd2 = 0; wb_reg = 0; wb_data = 0;
  endtask

  task automatic randomize_inputs();
    stall = $urandom_range(0, 4) == 0;
    flush = $urandom_range(0, 9) == 0;
    in_valid = $urandom_range(0, 3) != 0;
    rs = 5'($urandom_range(0, 7)); rt = 5'($urandom_range(0, 7));
    rd = 5'($urandom); shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom);
    c = 9'($urandom);
    rd1 = $urandom; rd2 = $urandom;
    wb_en = $urandom_range(0, 1) == 1; wb_reg = 5'($urandom_range(0, 7)); wb_data = $urandom;
  endtask

  initial begin
    m = '0;
    idle();
    #1;
    check_all();
    stall = 1; flush = 1; in_valid = 1; c = '1; rd1 = 32'hFFFF_FFFF;
    tick();
    tick();
    idle();
    #2 rst_n = 1;
    in_valid = 1; rs = 3; rd1 = 32'hDEAD_BEEF; imm = 16'h8001; c = 9'b1_0000_0000;
    tick();
    chk("cap_valid", 32'(ex_valid), 32'd1);
    chk("cap_data1", ex_d1, 32'hDEAD_BEEF);
    chk("cap_imm", ex_imm, 32'hFFFF_8001);
    chk("cap_rw", 32'(ex_rw), 32'd1);
    idle(); in_valid = 1; rd1 = 32'h1234; c = 9'b1_0000_0000;
    tick();
    #2 rst_n = 0;
    #1 m = '0;
    check_all();
    chk("async_rst_data1", ex_d1, 32'd0);
    stall = 1; flush = 1;
    tick();
    idle();
    #2 rst_n = 1;
    tick();
    in_valid = 1; rt = 5; c = 9'b1_1000_0000;
    tick();
    in_valid = 1; rs = 5; rt = 1; rd1 = 32'h55; c = 9'b1_0000_0001;
    #1 chk("lu_raise", 32'(lus), 32'd1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 32'd0);
    chk("lu_bubble_ctrl", 32'({ex_rw, ex_mr, ex_mw, ex_m2r, ex_as, ex_rdst, ex_op}), 32'd0);
    tick();
    chk("lu_capture_valid", 32'(ex_valid), 32'd1);
    chk("lu_capture_rs", 32'(ex_rs), 32'd5);
    idle(); in_valid = 1; c = 9'b1_0100_0000;
    tick();
    flush = 1; stall = 1;
    tick();
    chk("fs_valid", 32'(ex_valid), 32'd0);
    chk("fs_rw", 32'(ex_rw), 32'd0);
    chk("fs_mw", 32'(ex_mw), 32'd0);
    idle(); in_valid = 1; wb_en = 1; wb_reg = 7; wb_data = 32'h42; rt = 7; rd2 = 0;
    tick();
`ifdef WB_BYPASS_EN
    chk("byp_data2", ex_d2, 32'h42);
`else
    chk("byp_data2", ex_d2, 32'h0);
`endif
    wb_reg = 0; rt = 0; rd2 = 32'h77;
    tick();
    chk("byp_r0_data2", ex_d2, 32'h77);
    idle(); in_valid = 1; rt = 0; c = 9'b0_1000_0000; rd1 = 32'hABCD;
    tick();
    for (int i = 0; i < 3; i++) begin
      randomize_inputs();
      stall = 1; flush = 0; rs = 0; rt = 0;
      tick();
      chk("hold_data1", ex_d1, 32'hABCD);
    end
    for (int i = 0; i < 400; i++) begin
      randomize_inputs();
      tick();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have ports: Clk  in  1  rising-edge clock; Reset_n  in  1  async active-low reset.
REQ-002 SHALL have ports: Stall  in  1  hold stage; Flush  in  1  squash stage; InValid  in  1  decode slot holds an instruction.
REQ-003 SHALL have ports: Rs, Rt, Rd, Shamt  in  5 each  decoded fields; Imm  in  16  immediate; Funct  in  6  function code.
REQ-004 SHALL have ports: RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst  in  1 each  decode controls; ALUOp  in  3  ALU class.
REQ-005 SHALL have ports: ReadData1, ReadData2  in  32 each  combinational register-file read data for Rs/Rt.
REQ-006 SHALL have ports: WbEn  in  1  writeback enable; WbReg  in  5  writeback register; WbData  in  32  writeback data (same signals driving the register file write port).
REQ-007 SHALL have ports: ExValid  out  1; ExRs, ExRt, ExRd, ExShamt  out  5 each; ExFunct  out  6; ExImm  out  32  sign-extended; ExData1, ExData2  out  32 each.
REQ-008 SHALL have ports: ExRegWrite, ExMemRead, ExMemWrite, ExMemToReg, ExALUSrc, ExRegDst  out  1 each; ExALUOp  out  3; LoadUseStall  out  1  load-use hazard, holds IF/ID.

Function
REQ-009 SHALL register all Ex* outputs on rising Clk; one-cycle latency from decode inputs to Ex* outputs.
REQ-010 SHALL produce ExImm as {16{Imm[15]}, Imm} captured with the other fields.
REQ-011 SHALL assert LoadUseStall combinationally when ExValid & ExMemRead & InValid & ExRt!=0 & (ExRt==Rs | ExRt==Rt).
REQ-012 Per-cycle priority SHALL be: Flush > Stall > LoadUseStall > capture.
REQ-013 On Flush: ExValid<=0 and all Ex control bits (RegWrite, MemRead, MemWrite, MemToReg, ALUSrc, RegDst, ALUOp) <=0; data/field outputs don't-care but SHALL be cleared to 0.
REQ-014 On Stall (no Flush): every output register SHALL hold its value.
REQ-015 On LoadUseStall (no Flush/Stall): insert bubble, ExValid<=0, Ex control bits <=0; field/data registers hold.
REQ-016 On capture: ExValid<=InValid; controls<=inputs gated by InValid (all 0 when InValid=0); fields and data <=inputs.
REQ-017 Stage SHALL be a two-state machine, EMPTY (ExValid=0) / FULL (ExValid=1), transitions per REQ-012..016 only.
REQ-018 A bubble SHALL last exactly one cycle: after it ExValid=0, so LoadUseStall deasserts and the held instruction is captured next cycle.
REQ-019 ExRt==0 SHALL never raise LoadUseStall (register 0 is constant).

Reset
REQ-020 Reset_n low SHALL immediately (asynchronously) clear every output register to 0, ExValid=0; LoadUseStall consequently 0.
REQ-021 Reset deassertion SHALL take effect on the next rising Clk; Stall/Flush during reset SHALL be ignored.
REQ-022 Reset mid-operation SHALL discard the in-flight instruction with no partial state retained.

Configuration
REQ-023 Macro WB_BYPASS_EN: when defined, captured ExData1 SHALL be WbData if WbEn & WbReg!=0 & WbReg==Rs, else ReadData1; same for ExData2/Rt.
REQ-024 Without WB_BYPASS_EN, ExData1/ExData2 SHALL capture ReadData1/ReadData2 unmodified (register file must then write before read by other means).
REQ-025 Bypass SHALL apply only on capture cycles; held/bubble/flush cycles ignore WbEn.

Verification
REQ-026 Reset: Reset_n=0 mid-cycle with ExValid=1, ExData1=0x1234 -> all outputs 0 before next Clk edge.
REQ-027 Capture: InValid=1, Rs=3, ReadData1=0xDEADBEEF, Imm=0x8001, RegWrite=1 -> next cycle ExValid=1, ExData1=0xDEADBEEF, ExImm=0xFFFF8001, ExRegWrite=1.
REQ-028 Load-use: EX holds lw ExRt=5, ExMemRead=1; decode InValid=1, Rs=5 -> LoadUseStall=1, next cycle ExValid=0, all Ex controls 0, then instruction captured following cycle.
REQ-029 Flush+Stall same cycle with ExValid=1 -> next cycle ExValid=0, ExRegWrite=0, ExMemWrite=0.
REQ-030 Bypass (WB_BYPASS_EN): WbEn=1, WbReg=7, WbData=0x00000042, Rt=7, ReadData2=0x0 -> ExData2=0x00000042; WbReg=0 -> ExData2=ReadData2; without macro -> ExData2=0x0.
REQ-031 Stall hold: Stall=1 for 3 cycles while inputs change -> all Ex outputs unchanged; LoadUseStall=1 with ExRt=0 never observed.
